gps_axi_lite_slave: RTL and testbench

AXI4-Lite slave register file for the GPS IP: terminates the AXI4-Lite master BFM (and, on silicon, the PS GP port) and exposes four 32-bit control/status registers to the GPS core. It handles the AW/W/B and AR/R channels with independent write and read state machines. Each write commit produces a one-cycle per-register strobe for the core.

---
 rtl/gps_axi_lite_slave.sv | 135 +++++++++++++
 tb/tb_gps_axi_lite_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_axi_lite_slave.sv
// AXI4-Lite slave exposing four 32-bit control/status registers to the GPS core.
// Independent write (AW/W/B) and read (AR/R) FSMs; every output is registered.
module gps_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                        AWPROT,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                              WVALID,
  output logic                              WREADY,
  output logic [1:0]                        BRESP,
  output logic                              BVALID,
  input  logic                              BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [2:0]                        ARPROT,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [3:0]                        wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t            w_state;
  r_state_t            r_state;
  logic [3:0][DW-1:0]  regs;
  logic                aw_held, w_held;
  logic [1:0]          aw_sel;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wstrb_q;

  // protection bits and byte-offset address bits carry no meaning here
  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR, ARADDR};

  assign BRESP   = 2'b00;
  assign RRESP   = 2'b00;
  assign reg_out = regs;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      regs     <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            for (int i = 0; i < DW/8; i++)
              if (wstrb_q[i]) regs[aw_sel][8*i +: 8] <= wdata_q[8*i +: 8];
            wr_pulse[aw_sel] <= 1'b1;
            BVALID  <= 1'b1;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            w_state <= W_RESP;
          end else begin
            if (AWVALID && AWREADY) begin
              aw_held <= 1'b1;
              aw_sel  <= AWADDR[3:2];
            end
            if (WVALID && WREADY) begin
              w_held  <= 1'b1;
              wdata_q <= WDATA;
              wstrb_q <= WSTRB;
            end
            // ready drops the cycle after its channel is captured
            AWREADY <= !(aw_held || (AWVALID && AWREADY));
            WREADY  <= !(w_held  || (WVALID  && WREADY));
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // reads sample regs before this edge's commit, so a colliding read sees old data
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RDATA   <= regs[ARADDR[3:2]];
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gps_axi_lite_slave.sv
// Self-checking bench for gps_axi_lite_slave: vector table, randomized traffic
// against a register-array model, and directed multi-cycle corner cases.
module tb_gps_axi_lite_slave;
  logic         ACLK = 1'b0, ARESETN = 1'b0;
  logic [3:0]   AWADDR = '0, ARADDR = '0;
  logic [2:0]   AWPROT = '0, ARPROT = '0;
  logic         AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]   BRESP, RRESP;
  logic [31:0]  RDATA;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;

  gps_axi_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] model [4];
  int          exp_pulse [4];
  int          pulse_cnt [4] = '{default: 0};

  always @(negedge ACLK)
    if (ARESETN)
      for (int i = 0; i < 4; i++)
        if (wr_pulse[i]) pulse_cnt[i]++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[3:2]][8*i +: 8] = d[8*i +: 8];
    exp_pulse[a[3:2]]++;
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, b_done = 0, awr, wr, bv;
    int c = 0, bc = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!b_done && c < 200) begin
      AWVALID = !aw_done && c >= aw_dly;
      WVALID  = !w_done && c >= w_dly;
      BREADY  = bc >= b_dly;
      awr = AWREADY; wr = WREADY; bv = BVALID;
      if (bv && BREADY) check("bresp", 32'(BRESP), 32'h0);
      @(posedge ACLK); #1;
      if (AWVALID && awr) aw_done = 1;
      if (WVALID && wr) w_done = 1;
      if (BREADY && bv) b_done = 1;
      if (bv) bc++;
      c++;
    end
    AWVALID = 0; WVALID = 0; BREADY = 0;
    if (!b_done) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: actual no B handshake required B handshake (addr %0h)", a);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly, output logic [31:0] d);
    bit ar_done = 0, r_done = 0, arr, rv;
    int c = 0, rc = 0;
    ARADDR = a; d = '0;
    while (!r_done && c < 200) begin
      ARVALID = !ar_done;
      RREADY  = ar_done && rc >= r_dly;
      arr = ARREADY; rv = RVALID;
      if (rv && RREADY) begin
        d = RDATA;
        check("rresp", 32'(RRESP), 32'h0);
      end
      @(posedge ACLK); #1;
      if (ARVALID && arr) ar_done = 1;
      if (RREADY && rv) r_done = 1;
      if (rv) rc++;
      c++;
    end
    ARVALID = 0; RREADY = 0;
    if (!r_done) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout: actual no R handshake required R handshake (addr %0h)", a);
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl [5];
    logic [31:0] rd;
    int          snap [4];

    tbl[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
    tbl[1] = '{4'h4, 32'habcd0001, 4'hF, 32'habcd0001};
    tbl[2] = '{4'h8, 32'hdead0011, 4'hF, 32'hdead0011};
    tbl[3] = '{4'hC, 32'hbeef0011, 4'hF, 32'hbeef0011};
    tbl[4] = '{4'h4, 32'h11223344, 4'h5, 32'hab220044};
    for (int i = 0; i < 4; i++) begin model[i] = '0; exp_pulse[i] = 0; end

    // reset state
    #12;
    check("rst_awready", 32'(AWREADY), 0);
    check("rst_wready",  32'(WREADY), 0);
    check("rst_arready", 32'(ARREADY), 0);
    check("rst_bvalid",  32'(BVALID), 0);
    check("rst_rvalid",  32'(RVALID), 0);
    check("rst_rdata",   RDATA, 0);
    check("rst_pulse",   32'(wr_pulse), 0);
    for (int i = 0; i < 4; i++) check("rst_reg", reg_out[32*i +: 32], 0);
    @(negedge ACLK); ARESETN = 1;
    @(posedge ACLK); #1;
    check("post_rst_awready", 32'(AWREADY), 1);
    check("post_rst_wready",  32'(WREADY), 1);
    check("post_rst_arready", 32'(ARREADY), 1);

    // vector table
    for (int i = 0; i < 4; i++) snap[i] = pulse_cnt[i];
    for (int i = 0; i < 5; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0);
      model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      check("tbl_reg_out", reg_out[32*tbl[i].addr[3:2] +: 32], tbl[i].exp);
      axi_read(tbl[i].addr, 0, rd);
      check("tbl_readback", rd, tbl[i].exp);
      if (i == 3)
        for (int j = 0; j < 4; j++) check("tbl_pulse_once", pulse_cnt[j] - snap[j], 1);
    end

    // W arrives three cycles ahead of AW
    AWADDR = 4'h8; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); #1; WVALID = 0;
    check("wearly_wready_drop", 32'(WREADY), 0);
    repeat (2) begin
      @(posedge ACLK); #1;
      check("wearly_bvalid_low", 32'(BVALID), 0);
      check("wearly_reg2_hold", reg_out[64 +: 32], 32'hdead0011);
    end
    AWVALID = 1;
    @(posedge ACLK); #1; AWVALID = 0;
    check("wearly_aw_bvalid_low", 32'(BVALID), 0);
    check("wearly_aw_reg2_hold", reg_out[64 +: 32], 32'hdead0011);
    @(posedge ACLK); #1;
    check("wearly_bvalid", 32'(BVALID), 1);
    check("wearly_reg2", reg_out[64 +: 32], 32'h12345678);
    check("wearly_pulse", 32'(wr_pulse), 32'h4);
    model_write(4'h8, 32'h12345678, 4'hF);
    BREADY = 1;
    @(posedge ACLK); #1; BREADY = 0;
    check("wearly_bvalid_clr", 32'(BVALID), 0);
    check("wearly_pulse_clr", 32'(wr_pulse), 0);

    // BREADY withheld: no new AW accepted
    AWADDR = 4'hC; WDATA = 32'h55aa55aa; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1; AWVALID = 0; WVALID = 0;
    check("bhold_bvalid_n", 32'(BVALID), 0);
    @(posedge ACLK); #1;
    check("bhold_latency", 32'(BVALID), 1);
    model_write(4'hC, 32'h55aa55aa, 4'hF);
    AWADDR = 4'h0; AWVALID = 1;
    repeat (5) begin
      @(posedge ACLK); #1;
      check("bhold_bvalid", 32'(BVALID), 1);
      check("bhold_awready", 32'(AWREADY), 0);
      check("bhold_wready", 32'(WREADY), 0);
    end
    AWVALID = 0; BREADY = 1;
    @(posedge ACLK); #1; BREADY = 0;
    check("bhold_bvalid_clr", 32'(BVALID), 0);
    check("bhold_awready_back", 32'(AWREADY), 1);
    check("bhold_reg0_intact", reg_out[0 +: 32], model[0]);
    axi_write(4'h0, 32'h0badf00d, 4'hF, 0, 0, 0);
    model_write(4'h0, 32'h0badf00d, 4'hF);
    axi_read(4'h0, 0, rd); check("bhold_next_write", rd, 32'h0badf00d);
    axi_read(4'hC, 0, rd); check("bhold_reg3", rd, 32'h55aa55aa);

    // commit and AR on the same edge
    axi_write(4'h8, 32'hdead0011, 4'hF, 0, 0, 0);
    model_write(4'h8, 32'hdead0011, 4'hF);
    AWADDR = 4'h8; WDATA = 32'hcafef00d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1; AWVALID = 0; WVALID = 0;
    ARADDR = 4'h8; ARVALID = 1;
    @(posedge ACLK); #1; ARVALID = 0;
    check("coll_rvalid", 32'(RVALID), 1);
    check("coll_old_data", RDATA, 32'hdead0011);
    check("coll_reg2_new", reg_out[64 +: 32], 32'hcafef00d);
    model_write(4'h8, 32'hcafef00d, 4'hF);
    RREADY = 1; BREADY = 1;
    @(posedge ACLK); #1; RREADY = 0; BREADY = 0;
    axi_read(4'h8, 0, rd); check("coll_next_read", rd, 32'hcafef00d);

    // randomized traffic against the model
    for (int i = 0; i < 4; i++) snap[i] = pulse_cnt[i] - exp_pulse[i];
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
        model_write(a, d, WSTRB);
      end else begin
        axi_read(a, $urandom_range(0, 2), rd);
        check("rand_read", rd, model[a[3:2]]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      check("rand_reg_out", reg_out[32*i +: 32], model[i]);
      check("rand_pulse_count", pulse_cnt[i] - exp_pulse[i], snap[i]);
    end

    // reset while RVALID is up and a W is held
    ARADDR = 4'h4; ARVALID = 1;
    @(posedge ACLK); #1; ARVALID = 0;
    check("rst_mid_rvalid_up", 32'(RVALID), 1);
    WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); #1; WVALID = 0;
    check("rst_mid_w_held", 32'(WREADY), 0);
    #3 ARESETN = 0;
    #1;
    check("rst_mid_rvalid", 32'(RVALID), 0);
    check("rst_mid_bvalid", 32'(BVALID), 0);
    check("rst_mid_readies", 32'({AWREADY, WREADY, ARREADY}), 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_reg", reg_out[32*i +: 32], 0);
      model[i] = '0;
    end
    @(negedge ACLK); ARESETN = 1;
    @(posedge ACLK); #1;
    check("rst_mid_ready_back", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
    axi_read(4'h4, 0, rd); check("rst_mid_read4", rd, 32'h0);
    repeat (3) @(posedge ACLK);
    check("rst_mid_no_commit", reg_out[32 +: 32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
